// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the RiSC-16 core. Owns the PC, reads one
// instruction word at a time from instruction memory, holds it for the
// decoder and forms the next PC when the datapath retires the instruction.
//
// Handshakes:
//   imem_req/imem_ack : imem_req is high for the whole FETCH state, and
//                       imem_addr (= pc) is stable while it is high. A cycle
//                       with imem_ack=1 in FETCH completes the read and
//                       captures imem_rdata. imem_ack outside FETCH is ignored.
//   instr_valid/advance: instr_valid is high in VALID. A cycle with
//                       advance=1 in VALID retires the instruction. mux_pc and
//                       jalr_tgt are sampled on that edge only. advance outside
//                       VALID is ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     instruction read request and address (current PC)
//   imem_ack/rdata    read completion and returned instruction word
//   instr_valid       instr/opcode/pc describe a fetched instruction
//   instr, opcode     held instruction and its opcode field instr[15:13]
//   pc, pc_plus1      address of held instruction and pc+1 (JALR link)
//   advance           datapath retires the held instruction
//   mux_pc            next-PC select: 00 jalr_tgt, 01 pc+1, 10 branch, 11 rsvd
//   jalr_tgt          register-sourced jump target
//   sel_err           sticky: an instruction retired with mux_pc=11
//   dbg_state         current FSM state (IDLE=0, FETCH=1, VALID=2)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    input  logic              advance,
    input  logic [1:0]        mux_pc,
    input  logic [ADDR_W-1:0] jalr_tgt,
    output logic              sel_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                sel_err_q, sel_err_d;

    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   imm_ext;
    logic [ADDR_W-1:0]   br_tgt;

    // Branch offset is the 7-bit signed immediate in instr[6:0], relative to pc+1.
    assign pc_inc  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign imm_ext = {{(ADDR_W-7){instr_q[6]}}, instr_q[6:0]};
    assign br_tgt  = pc_inc + imm_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC[ADDR_W-1:0];
            instr_q   <= 16'h0000;
            valid_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        sel_err_d = sel_err_q;
        imem_req  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // Request is a pure decode of state so reset drops it at once.
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (advance) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                    case (mux_pc)
                        2'b00: pc_d = jalr_tgt;
                        2'b01: pc_d = pc_inc;
                        2'b10: pc_d = br_tgt;
                        default: begin
                            // Reserved select: fall through sequentially, flag it.
                            pc_d      = pc_inc;
                            sel_err_d = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[15:13];
    assign pc          = pc_q;
    assign pc_plus1    = pc_inc;
    assign sel_err     = sel_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The driver pushes the expected fetch address
// when it causes a new fetch, and the expected {pc, instr} when it supplies an
// instruction word. A monitor pops and compares on every rising edge of
// imem_req and of instr_valid. Inline checks cover stability, ignore rules,
// sel_err and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        advance;
    logic [1:0]  mux_pc;
    logic [15:0] jalr_tgt;
    logic        sel_err;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    logic req_prev;
    logic valid_prev;

    fetch_unit #(.RESET_PC(16'h0000), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .opcode     (opcode),
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .advance    (advance),
        .mux_pc     (mux_pc),
        .jalr_tgt   (jalr_tgt),
        .sel_err    (sel_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && !req_prev) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_req", {16'h0, imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("fetch_addr", {16'h0, imem_addr}, {16'h0, exp_addr_q.pop_front()});
                end
            end
            if (instr_valid && !valid_prev) begin
                if (exp_instr_q.size() == 0) begin
                    check("unexpected_valid", {pc, instr}, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_instr_q.pop_front();
                    check("held_pc_instr", {pc, instr}, e);
                    check("opcode", {29'h0, opcode}, {29'h0, e[15:13]});
                    check("pc_plus1", {16'h0, pc_plus1}, {16'h0, e[31:16] + 16'h1});
                end
            end
        end
        req_prev   <= imem_req;
        valid_prev <= instr_valid;
    end

    // ---------------- driver tasks ----------------
    // Waits for the request, holds ack low for wait_n cycles, then returns data.
    task automatic do_fetch(input logic [15:0] data, input int wait_n, input logic [15:0] exp_pc);
        int guard;
        guard = 0;
        while (!imem_req && guard < 20) begin
            tick();
            guard++;
        end
        if (!imem_req) begin
            check("req_timeout", {31'h0, imem_req}, 32'h1);
            return;
        end
        exp_instr_q.push_back({exp_pc, data});
        for (int i = 0; i < wait_n; i++) begin
            check("wait_req", {31'h0, imem_req}, 32'h1);
            check("wait_addr", {16'h0, imem_addr}, {16'h0, exp_pc});
            check("wait_no_valid", {31'h0, instr_valid}, 32'h0);
            tick();
        end
        check("ack_cycle_addr", {16'h0, imem_addr}, {16'h0, exp_pc});
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check("post_ack_req", {31'h0, imem_req}, 32'h0);
    endtask

    task automatic do_advance(input logic [1:0] sel, input logic [15:0] tgt, input logic [15:0] exp_addr);
        exp_addr_q.push_back(exp_addr);
        advance  = 1'b1;
        mux_pc   = sel;
        jalr_tgt = tgt;
        tick();
        advance  = 1'b0;
        mux_pc   = 2'b00;
        jalr_tgt = 16'h0000;
        check("adv_valid_drop", {31'h0, instr_valid}, 32'h0);
        check("adv_next_addr", {16'h0, imem_addr}, {16'h0, exp_addr});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        advance    = 1'b0;
        mux_pc     = 2'b00;
        jalr_tgt   = 16'h0000;
        req_prev   = 1'b0;
        valid_prev = 1'b0;

        repeat (3) tick();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_instr", {16'h0, instr}, 32'h0);
        check("rst_sel_err", {31'h0, sel_err}, 32'h0);

        // Reset release: request one edge later at RESET_PC, zero-wait memory.
        exp_addr_q.push_back(16'h0000);
        rst_n = 1'b1;
        tick();
        check("req_after_release", {31'h0, imem_req}, 32'h1);
        do_fetch(16'h2A85, 0, 16'h0000);

        // JALR to 0010, then 4-cycle delayed ack of a BEQ with imm=-2.
        do_advance(2'b00, 16'h0010, 16'h0010);
        do_fetch(16'hC07E, 4, 16'h0010);
        do_advance(2'b10, 16'h0000, 16'h000F);
        do_fetch(16'h6001, 0, 16'h000F);
        do_advance(2'b00, 16'h0010, 16'h0010);
        do_fetch(16'hC07E, 1, 16'h0010);
        do_advance(2'b01, 16'h0000, 16'h0011);
        do_fetch(16'h8001, 0, 16'h0011);

        // Wrap-around at FFFF, then a plain JALR.
        do_advance(2'b00, 16'hFFFF, 16'hFFFF);
        do_fetch(16'h4242, 0, 16'hFFFF);
        do_advance(2'b01, 16'h0000, 16'h0000);
        do_fetch(16'hE000, 0, 16'h0000);
        do_advance(2'b00, 16'h1234, 16'h1234);
        do_fetch(16'hA5A5, 2, 16'h1234);

        // Branch with imm7=40 (-64) from 0010 wraps below zero.
        do_advance(2'b00, 16'h0010, 16'h0010);
        do_fetch(16'hC040, 0, 16'h0010);
        do_advance(2'b10, 16'h0000, 16'hFFD1);

        // advance during FETCH is ignored.
        advance  = 1'b1;
        mux_pc   = 2'b00;
        jalr_tgt = 16'hBEEF;
        tick();
        advance  = 1'b0;
        jalr_tgt = 16'h0000;
        check("ign_adv_addr", {16'h0, imem_addr}, 32'h0000_FFD1);
        check("ign_adv_req", {31'h0, imem_req}, 32'h1);
        do_fetch(16'h2222, 0, 16'hFFD1);

        // ack during VALID is ignored.
        imem_ack   = 1'b1;
        imem_rdata = 16'hFFFF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        tick();
        check("ign_ack_instr", {16'h0, instr}, 32'h0000_2222);
        check("ign_ack_pc", {16'h0, pc}, 32'h0000_FFD1);
        check("ign_ack_valid", {31'h0, instr_valid}, 32'h1);

        // Reserved select.
        do_advance(2'b00, 16'h0005, 16'h0005);
        do_fetch(16'h3333, 0, 16'h0005);
        check("sel_err_clear", {31'h0, sel_err}, 32'h0);
        do_advance(2'b11, 16'h0000, 16'h0006);
        check("sel_err_set", {31'h0, sel_err}, 32'h1);
        do_fetch(16'h4444, 3, 16'h0006);
        check("sel_err_sticky", {31'h0, sel_err}, 32'h1);

        // Reset mid-FETCH, with an ack arriving during reset.
        do_advance(2'b01, 16'h0000, 16'h0007);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        check("midrst_sel_err", {31'h0, sel_err}, 32'h0);
        check("midrst_pc", {16'h0, pc}, 32'h0);
        check("midrst_valid", {31'h0, instr_valid}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        tick();
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check("midrst_instr", {16'h0, instr}, 32'h0);
        exp_addr_q.push_back(16'h0000);
        rst_n = 1'b1;
        tick();
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", {16'h0, imem_addr}, 32'h0);
        do_fetch(16'h7777, 0, 16'h0000);

        repeat (3) tick();
        check("addr_q_empty", exp_addr_q.size(), 32'h0);
        check("instr_q_empty", exp_instr_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
